// File: rtl/mem_req_arbiter.sv
// Two-port (instruction/data) memory request arbiter with in-order response routing.
// Optional round-robin arbitration is enabled by defining ARB_RR_EN; default is fixed data-port priority.
module mem_req_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        s0_req,
    input  logic        s0_wr,
    input  logic [1:0]  s0_size,
    input  logic [31:0] s0_addr,
    input  logic [3:0]  s0_wstrb,
    input  logic [31:0] s0_wdata,
    output logic        s0_addr_ok,
    output logic        s0_data_ok,

    input  logic        s1_req,
    input  logic        s1_wr,
    input  logic [1:0]  s1_size,
    input  logic [31:0] s1_addr,
    input  logic [3:0]  s1_wstrb,
    input  logic [31:0] s1_wdata,
    output logic        s1_addr_ok,
    output logic        s1_data_ok,

    output logic [31:0] s_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          lock_q, lock_d;
    logic          lock_id_q, lock_id_d;
    logic          fifo_q [DEPTH];
    logic          fifo_d [DEPTH];
`ifdef ARB_RR_EN
    logic          last_q, last_d;
`endif

    logic sel;
    logic full;
    logic push;
    logic pop;
    logic head_id;

    // A request left waiting on m_addr_ok keeps ownership of the bus until accepted.
    always_comb begin
        sel = 1'b0;
        if (lock_q) begin
            sel = lock_id_q;
        end
`ifdef ARB_RR_EN
        else if (s0_req && s1_req) begin
            sel = ~last_q;
        end
`endif
        else begin
            sel = s1_req;
        end
    end

    assign full    = (count_q == CW'(DEPTH));
    assign m_req   = (s0_req | s1_req) & ~full & ~rst;
    assign push    = m_req & m_addr_ok;
    assign head_id = fifo_q[rd_ptr_q];
    assign pop     = m_data_ok & (count_q != '0) & ~rst;

    assign m_wr    = sel ? s1_wr    : s0_wr;
    assign m_size  = sel ? s1_size  : s0_size;
    assign m_addr  = sel ? s1_addr  : s0_addr;
    assign m_wstrb = sel ? s1_wstrb : s0_wstrb;
    assign m_wdata = sel ? s1_wdata : s0_wdata;

    assign s0_addr_ok = push & ~sel;
    assign s1_addr_ok = push & sel;
    assign s0_data_ok = pop & ~head_id;
    assign s1_data_ok = pop & head_id;
    assign s_rdata    = m_rdata;

    always_comb begin
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        fifo_d    = fifo_q;
`ifdef ARB_RR_EN
        last_d    = last_q;
`endif

        if (push) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = wr_ptr_q + PW'(1);
            lock_d           = 1'b0;
`ifdef ARB_RR_EN
            last_d           = sel;
`endif
        end else if (m_req) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
`ifdef ARB_RR_EN
            // Pretend port 1 won last so port 0 has priority first.
            last_q    <= 1'b1;
`endif
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
`ifdef ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    // ID storage needs no reset: entries are only read behind a nonzero count.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter (DEPTH=4); expectations adapt when ARB_RR_EN is defined.
module tb_mem_req_arbiter;

    logic        clk;
    logic        rst;
    logic        s0_req, s0_wr, s1_req, s1_wr;
    logic [1:0]  s0_size, s1_size;
    logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
    logic [3:0]  s0_wstrb, s1_wstrb;
    logic        s0_addr_ok, s0_data_ok, s1_addr_ok, s1_data_ok;
    logic [31:0] s_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wstrb_unused, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    int checks;
    int failures;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mem_req_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .s0_req(s0_req), .s0_wr(s0_wr), .s0_size(s0_size), .s0_addr(s0_addr),
        .s0_wstrb(s0_wstrb), .s0_wdata(s0_wdata), .s0_addr_ok(s0_addr_ok), .s0_data_ok(s0_data_ok),
        .s1_req(s1_req), .s1_wr(s1_wr), .s1_size(s1_size), .s1_addr(s1_addr),
        .s1_wstrb(s1_wstrb), .s1_wdata(s1_wdata), .s1_addr_ok(s1_addr_ok), .s1_data_ok(s1_data_ok),
        .s_rdata(s_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wstrb(m_wstrb), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic r1, input logic a_ok,
                                 input logic d_ok, input logic [31:0] rdata);
        s0_req    = r0;
        s1_req    = r1;
        m_addr_ok = a_ok;
        m_data_ok = d_ok;
        m_rdata   = rdata;
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkGrant(input string tag, input logic exp_req, input logic exp_ok0, input logic exp_ok1);
        checkOutput({tag, "_m_req"}, 32'(m_req), 32'(exp_req));
        checkOutput({tag, "_s0_addr_ok"}, 32'(s0_addr_ok), 32'(exp_ok0));
        checkOutput({tag, "_s1_addr_ok"}, 32'(s1_addr_ok), 32'(exp_ok1));
    endtask

    task automatic checkResp(input string tag, input logic exp0, input logic exp1);
        checkOutput({tag, "_s0_data_ok"}, 32'(s0_data_ok), 32'(exp0));
        checkOutput({tag, "_s1_data_ok"}, 32'(s1_data_ok), 32'(exp1));
    endtask

    logic first;
    logic [31:0] first_addr;

    initial begin
        checks = 0;
        failures = 0;
        m_wstrb_unused = '0;
        s0_wr = 1'b0; s0_size = 2'd2; s0_addr = 32'h0000_0100; s0_wstrb = 4'h0; s0_wdata = 32'h0;
        s1_wr = 1'b0; s1_size = 2'd2; s1_addr = 32'h0000_0200; s1_wstrb = 4'h0; s1_wdata = 32'h0;

        // Reset holds all handshakes low even with live requests and responses
        rst = 1'b1;
        applyStimulus(1, 1, 1, 1, 32'h0);
        nextCycle();
        #2;
        checkGrant("reset", 0, 0, 0);
        checkResp("reset", 0, 0);
        nextCycle();
        rst = 1'b0;

        // Both ports request; fixed priority picks port 1, round-robin picks port 0 first
        first      = RR ? 1'b0 : 1'b1;
        first_addr = RR ? 32'h0000_0100 : 32'h0000_0200;
        applyStimulus(1, 1, 1, 0, 32'h0);
        #2;
        checkGrant("both_req", 1, ~first, first);
        checkOutput("both_req_m_addr", m_addr, first_addr);
        nextCycle();
        applyStimulus(first, ~first, 1, 0, 32'h0);
        #2;
        checkGrant("second_req", 1, first, ~first);
        checkOutput("second_req_m_addr", m_addr, RR ? 32'h0000_0200 : 32'h0000_0100);
        nextCycle();

        // Responses come back in acceptance order
        applyStimulus(0, 0, 0, 1, 32'hAAAA_0001);
        #2;
        checkResp("resp1", ~first, first);
        checkOutput("resp1_rdata", s_rdata, 32'hAAAA_0001);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'hAAAA_0002);
        #2;
        checkResp("resp2", first, ~first);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'hAAAA_0003);
        #2;
        checkResp("empty_resp", 0, 0);
        nextCycle();

        // Port 0 stalls 3 cycles; port 1 arriving mid-stall must not steal the bus
        s0_addr = 32'h0000_0300; s0_wr = 1'b1; s0_wstrb = 4'hC; s0_wdata = 32'hDEAD_BEEF; s0_size = 2'd1;
        s1_addr = 32'h0000_0400;
        applyStimulus(1, 0, 0, 0, 32'h0);
        #2;
        checkGrant("stall1", 1, 0, 0);
        checkOutput("stall1_m_addr", m_addr, 32'h0000_0300);
        nextCycle();
        applyStimulus(1, 1, 0, 0, 32'h0);
        #2;
        checkGrant("stall2", 1, 0, 0);
        checkOutput("stall2_m_addr", m_addr, 32'h0000_0300);
        nextCycle();
        #2;
        checkOutput("stall3_m_addr", m_addr, 32'h0000_0300);
        nextCycle();
        applyStimulus(1, 1, 1, 0, 32'h0);
        #2;
        checkGrant("stall_accept", 1, 1, 0);
        checkOutput("stall_m_wdata", m_wdata, 32'hDEAD_BEEF);
        checkOutput("stall_m_wstrb", 32'(m_wstrb), 32'h0000_000C);
        checkOutput("stall_m_wr", 32'(m_wr), 32'h1);
        checkOutput("stall_m_size", 32'(m_size), 32'h1);
        nextCycle();
        applyStimulus(0, 1, 1, 0, 32'h0);
        #2;
        checkGrant("after_lock", 1, 0, 1);
        checkOutput("after_lock_m_addr", m_addr, 32'h0000_0400);
        nextCycle();
        s0_wr = 1'b0; s0_wstrb = 4'h0; s0_size = 2'd2;

        // Write responses route like reads: s0 then s1
        applyStimulus(0, 0, 0, 1, 32'h0);
        #2;
        checkResp("wresp1", 1, 0);
        nextCycle();
        #2;
        checkResp("wresp2", 0, 1);
        nextCycle();

        // Fill to DEPTH with pointers wrapping: s0, s1, s0, s1
        applyStimulus(1, 0, 1, 0, 32'h0); nextCycle();
        applyStimulus(0, 1, 1, 0, 32'h0); nextCycle();
        applyStimulus(1, 0, 1, 0, 32'h0); nextCycle();
        applyStimulus(0, 1, 1, 0, 32'h0); nextCycle();

        // Full: no issue even with a same-cycle pop, resume next cycle
        applyStimulus(1, 0, 1, 1, 32'h1234_5678);
        #2;
        checkGrant("full", 0, 0, 0);
        checkResp("full_pop", 1, 0);
        checkOutput("full_pop_rdata", s_rdata, 32'h1234_5678);
        nextCycle();
        applyStimulus(1, 0, 1, 0, 32'h0);
        #2;
        checkGrant("resume", 1, 1, 0);
        nextCycle();

        // Remaining order after wrap: s1, s0, s1, s0
        applyStimulus(0, 0, 0, 1, 32'h0);
        #2; checkResp("drain1", 0, 1); nextCycle();
        #2; checkResp("drain2", 1, 0); nextCycle();
        #2; checkResp("drain3", 0, 1); nextCycle();
        #2; checkResp("drain4", 1, 0); nextCycle();
        #2; checkResp("drain_empty", 0, 0); nextCycle();

        // Two outstanding, then reset discards them
        applyStimulus(1, 0, 1, 0, 32'h0); nextCycle();
        applyStimulus(0, 1, 1, 0, 32'h0); nextCycle();
        rst = 1'b1;
        applyStimulus(1, 1, 1, 1, 32'h0);
        #2;
        checkGrant("mid_reset", 0, 0, 0);
        checkResp("mid_reset", 0, 0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 1, 32'h0);
        #2; checkResp("post_reset1", 0, 0); nextCycle();
        #2; checkResp("post_reset2", 0, 0); nextCycle();

        // Continuous contention: RR alternates 0,1,0,1; fixed always grants port 1
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 1, 0, 32'h0);
            #2;
            if (RR) checkGrant($sformatf("contend%0d", i), 1, (i % 2) == 0, (i % 2) == 1);
            else    checkGrant($sformatf("contend%0d", i), 1, 0, 1);
            nextCycle();
        end
        #2;
        checkGrant("contend_full", 0, 0, 0);
        nextCycle();

        applyStimulus(0, 0, 0, 0, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, maximum outstanding accepted-but-unanswered requests; power of two, at least 2.
REQ-002 SHALL have clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have s{0,1}_req  input  1  request valid; port 0 = instruction fetch, port 1 = data access.
REQ-005 SHALL have s{0,1}_wr  input  1  write request when high.
REQ-006 SHALL have s{0,1}_size  input  2  access size: 0 = byte, 1 = half, 2 = word.
REQ-007 SHALL have s{0,1}_addr  input  32  request address.
REQ-008 SHALL have s{0,1}_wstrb  input  4  byte write strobes.
REQ-009 SHALL have s{0,1}_wdata  input  32  write data.
REQ-010 SHALL have s{0,1}_addr_ok  output  1  request accepted this cycle.
REQ-011 SHALL have s{0,1}_data_ok  output  1  response for this port this cycle.
REQ-012 SHALL have s_rdata  output  32  read data broadcast to both ports.
REQ-013 SHALL have m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata  outputs  1/1/2/32/4/32  single downstream request.
REQ-014 SHALL have m_addr_ok  input  1  downstream accepted request.
REQ-015 SHALL have m_data_ok  input  1  downstream response valid.
REQ-016 SHALL have m_rdata  input  32  downstream read data.

Function
REQ-017 SHALL assert m_req = (s0_req | s1_req) & !full, where full = (outstanding count == DEPTH) from registered count only.
REQ-018 SHALL combinationally drive all m_* payload signals from the selected port.
REQ-019 SHALL, when not locked, select port 1 if s1_req is high, else port 0.
REQ-020 SHALL set a lock register (lock, lock_id) when m_req is high and m_addr_ok is low; while lock is set, selection SHALL equal lock_id regardless of the other port.
REQ-021 SHALL clear lock on the cycle m_req & m_addr_ok.
REQ-022 SHALL assert sN_addr_ok = m_req & m_addr_ok & (sel == N); the other port's addr_ok SHALL be 0.
REQ-023 SHALL, on acceptance, push sel into an in-order ID FIFO of DEPTH entries and increment count.
REQ-024 SHALL, on m_data_ok with count > 0, assert s{head}_data_ok for exactly that cycle, pop the FIFO, and decrement count.
REQ-025 SHALL treat write responses identically to read responses.
REQ-026 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-027 SHALL keep m_req low when full, even if a pop occurs in the same cycle; issue resumes the next cycle.
REQ-028 SHALL ignore m_data_ok when count == 0: no sN_data_ok and no count change.
REQ-029 SHALL let FIFO pointers wrap modulo DEPTH with no loss or reordering.
REQ-030 SHALL pass s_rdata = m_rdata combinationally.

Reset
REQ-031 SHALL, while rst is high, clear count, pointers, lock, and the round-robin pointer (next priority = port 0).
REQ-032 SHALL, while rst is high, force m_req, all addr_ok, and all data_ok to 0.
REQ-033 SHALL discard outstanding transactions on reset mid-operation; later m_data_ok is ignored per REQ-028.

Configuration
REQ-034 SHALL, when ARB_RR_EN is defined, replace REQ-019 with round-robin selection: with both requesting and not locked, grant the port not granted at the last acceptance; the pointer updates only on acceptance.
REQ-035 SHALL, when ARB_RR_EN is undefined, use fixed data-port priority per REQ-019 and contain no round-robin state.

Verification
REQ-036 SHALL cover: both ports request, m_addr_ok=1, fixed priority -> s1_addr_ok=1, s0_addr_ok=0; port 0 accepted the following cycle.
REQ-037 SHALL cover: s0 request, m_addr_ok=0 for 3 cycles, s1 rises in cycle 2 -> m_addr stays s0_addr; s0_addr_ok on cycle 4 only.
REQ-038 SHALL cover: DEPTH=4, 4 acceptances, no responses -> m_req=0; m_data_ok with m_rdata=0x12345678 -> data_ok to first requester with that rdata; m_req=1 the next cycle.
REQ-039 SHALL cover: ordered issues [s1,s0,s1] with 3 m_data_ok -> data_ok sequence s1,s0,s1; count returns to 0.
REQ-040 SHALL cover: m_data_ok with empty FIFO, and rst with 2 outstanding then 2 m_data_ok -> no sN_data_ok pulses.
REQ-041 SHALL cover, with ARB_RR_EN defined: both ports continuously requesting, m_addr_ok=1 -> grants alternate 0,1,0,1.
